rx_control: RTL and testbench
=============================

# rx_control

Receive-side counterpart of the bridge's transmit controller. Takes the byte stream from the Ethernet MAC receive interface (`valid`/`last`/`error` per byte) and writes accepted bytes into the receive frame buffer. Checks each frame for runt, oversize, MAC error and buffer overflow. Tells the buffer to commit the frame, or roll it back, and reports the frame length to the upstream logic.

## Interface
- `MIN_LEN`, 64: minimum legal frame length in bytes; shorter frames are dropped.
- `MAX_LEN`, 1518: maximum legal frame length in bytes; longer frames are dropped.
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `rx_data`  in  8  received byte from the MAC.
- `rx_data_valid`  in  1  `rx_data` is valid this cycle.
- `rx_last_byte`  in  1  final byte of the frame; qualified by `rx_data_valid`.
- `rx_error`  in  1  MAC-detected error (CRC or symbol); qualified by `rx_data_valid`.
- `full_buff`  in  1  receive buffer cannot accept a byte this cycle.
- `wr_data`  out  8  byte to the buffer.
- `wr_en`  out  1  write strobe for `wr_data`.
- `wr_commit`  out  1  one-cycle pulse: the pending frame is good; the buffer publishes it.
- `wr_rollback`  out  1  one-cycle pulse: the buffer discards the pending frame.
- `frm_len`  out  16  length of the last committed frame; held until the next commit.
- `frm_ok_cnt`  out  16  count of committed frames; wraps.
- `frm_drop_cnt`  out  16  count of dropped frames; wraps.

## Operation
- States:
  - IDLE: waiting for the first byte of a frame.
  - RECV: frame in progress, all bytes written so far.
  - DROP: frame already marked bad; remaining bytes discarded until last.
- Byte counter `cnt`: 16 bits, counts every valid byte of the current frame, saturates at `MAX_LEN+1`. It clears on commit or rollback.
- IDLE + valid byte:
  - Write the byte and set `cnt=1`.
  - Go to RECV, or to DROP if `rx_error` or `full_buff` is high.
  - If the same byte carries `rx_last_byte`, the frame ends immediately. It is a runt, so it is rolled back and the FSM returns to IDLE.
- RECV + valid byte:
  - The byte is bad if `rx_error`, `full_buff`, or `cnt+1 > MAX_LEN`.
  - Bad byte: not written; go to DROP.
  - Good byte: written.
- End of frame (`rx_last_byte` with valid, in RECV or DROP):
  - Good: state was RECV, the last byte is not bad, and `cnt+1 >= MIN_LEN`.
    - Pulse `wr_commit`, load `frm_len = cnt+1`, increment `frm_ok_cnt`.
  - Otherwise: pulse `wr_rollback`, increment `frm_drop_cnt`.
  - Return to IDLE in both cases.
- DROP: valid bytes are ignored (no `wr_en`) until the last byte.
- Simultaneous conditions:
  - Last byte together with error or full: drop.
  - A length of exactly `MAX_LEN` is accepted; `MAX_LEN+1` is dropped.
  - A length of exactly `MIN_LEN` is accepted.
- `rx_last_byte` or `rx_error` without `rx_data_valid`: ignored.
- Cycles with `rx_data_valid` low inside a frame: state held, no write.
- Reset mid-frame: FSM to IDLE; the pending frame is neither committed nor rolled back. The buffer shares `rst` and clears itself.

## Timing
- Reset values: all outputs 0; state IDLE; `cnt` 0.
- Latency: a byte sampled at edge N appears on `wr_data`/`wr_en` in the cycle after N, for exactly one cycle.
- `wr_commit`/`wr_rollback` are asserted in the same cycle as the `wr_en` of the last byte, or alone if that byte was discarded. The buffer treats a write plus commit in one cycle as write-then-commit.
- `frm_len` and the counters update on the same edge that raises `wr_commit`/`wr_rollback`.
- Back-to-back frames: a new frame's first byte may arrive in the cycle right after the previous last byte; no idle gap is required.
- `full_buff` is sampled on the same edge as the byte. A byte offered while full is never written.

## Structure
- Shared package `eth_bridge_pkg` holds:
  - the state enum `rx_state_t` (IDLE, RECV, DROP);
  - constants `ETH_MIN_LEN=64` and `ETH_MAX_LEN=1518`, which are the parameter defaults;
  - the 16-bit `len_t` typedef, also used for the transmitter's `frm_len`.
- One sub-module, `rx_stat_counters`, holds the two wrapping frame counters. It is driven by commit/rollback pulses.

## Test plan
- 64-byte frame 0x00..0x3F, no error, buffer never full -> 64 `wr_en` pulses with matching data, then `wr_commit` with `frm_len=64` and `frm_ok_cnt=1`.
- 63-byte frame -> 63 writes, then `wr_rollback`; `frm_drop_cnt=1`, `frm_len` unchanged.
- 100-byte frame with `rx_error` on byte 50 -> 49 writes, `wr_rollback` at the last byte, no `wr_commit`.
- `full_buff` high for byte 10 of a 70-byte frame -> writes stop after byte 9 and `wr_rollback` is pulsed. A following 64-byte frame, sent back-to-back, commits.
- 1518-byte frame -> `wr_commit` with `frm_len=1518`. 1519-byte frame -> 1518 writes, then `wr_rollback`.
- `rst` low at byte 30 of a frame -> all outputs 0 next cycle; the next full 64-byte frame commits normally.

Source files
------------

// File: rtl/eth_bridge_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : eth_bridge_pkg
// Purpose  : Shared types and constants for the Ethernet bridge data paths.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
package eth_bridge_pkg;

   typedef logic [15:0] len_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      DROP = 2'd2
   } rx_state_t;

   localparam len_t ETH_MIN_LEN = 16'd64;
   localparam len_t ETH_MAX_LEN = 16'd1518;

   function automatic len_t len_sat_inc(input len_t value, input len_t limit);
      return (value >= limit) ? limit : len_t'(value + 16'd1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/rx_stat_counters.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : rx_stat_counters
// Purpose  : Wrapping committed / dropped frame counters.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module rx_stat_counters
   import eth_bridge_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic i_ok_pulse,
   input  logic i_drop_pulse,
   output len_t o_ok_cnt,
   output len_t o_drop_cnt
);

   len_t r_ok_cnt;
   len_t r_drop_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ok_cnt   <= '0;
         r_drop_cnt <= '0;
      end else begin
         if (i_ok_pulse)
            r_ok_cnt <= r_ok_cnt + 16'd1;
         if (i_drop_pulse)
            r_drop_cnt <= r_drop_cnt + 16'd1;
      end
   end

   assign o_ok_cnt   = r_ok_cnt;
   assign o_drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: rtl/rx_control.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : rx_control
// Purpose  : MAC receive stream to frame buffer writer with length/error
//            screening and commit / rollback signalling.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module rx_control
   import eth_bridge_pkg::*;
#(
   parameter len_t MIN_LEN = ETH_MIN_LEN,
   parameter len_t MAX_LEN = ETH_MAX_LEN
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_data_valid,
   input  logic       rx_last_byte,
   input  logic       rx_error,
   input  logic       full_buff,
   output logic [7:0] wr_data,
   output logic       wr_en,
   output logic       wr_commit,
   output logic       wr_rollback,
   output len_t       frm_len,
   output len_t       frm_ok_cnt,
   output len_t       frm_drop_cnt
);

   localparam len_t c_cnt_sat = len_t'(MAX_LEN + 16'd1);

   rx_state_t  r_state;
   rx_state_t  w_state_nxt;
   len_t       r_cnt;
   len_t       w_cnt_nxt;
   len_t       w_len_plus;
   logic       w_bad;
   logic       w_wr_en;
   logic       w_commit;
   logic       w_rollback;

   logic [7:0] r_wr_data;
   logic       r_wr_en;
   logic       r_commit;
   logic       r_rollback;
   len_t       r_frm_len;

   assign w_len_plus = len_t'(r_cnt + 16'd1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_bad       = 1'b0;
      w_wr_en     = 1'b0;
      w_commit    = 1'b0;
      w_rollback  = 1'b0;
      case (r_state)
         IDLE: begin
            if (rx_data_valid) begin
               // A byte offered while the buffer is full is never written.
               w_wr_en   = !full_buff;
               w_cnt_nxt = 16'd1;
               if (rx_last_byte) begin
                  w_rollback = 1'b1;
                  w_cnt_nxt  = '0;
               end else if (rx_error || full_buff) begin
                  w_state_nxt = DROP;
               end else begin
                  w_state_nxt = RECV;
               end
            end
         end
         RECV: begin
            if (rx_data_valid) begin
               w_bad     = rx_error || full_buff || (w_len_plus > MAX_LEN);
               w_wr_en   = !w_bad;
               w_cnt_nxt = len_sat_inc(r_cnt, c_cnt_sat);
               if (rx_last_byte) begin
                  w_commit    = !w_bad && (w_len_plus >= MIN_LEN);
                  w_rollback  = !w_commit;
                  w_cnt_nxt   = '0;
                  w_state_nxt = IDLE;
               end else if (w_bad) begin
                  w_state_nxt = DROP;
               end
            end
         end
         DROP: begin
            if (rx_data_valid) begin
               w_cnt_nxt = len_sat_inc(r_cnt, c_cnt_sat);
               if (rx_last_byte) begin
                  w_rollback  = 1'b1;
                  w_cnt_nxt   = '0;
                  w_state_nxt = IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_data  <= '0;
         r_wr_en    <= 1'b0;
         r_commit   <= 1'b0;
         r_rollback <= 1'b0;
         r_frm_len  <= '0;
      end else begin
         r_wr_en    <= w_wr_en;
         r_commit   <= w_commit;
         r_rollback <= w_rollback;
         if (w_wr_en)
            r_wr_data <= rx_data;
         if (w_commit)
            r_frm_len <= w_len_plus;
      end
   end

   // Counters see the combinational strobes so they step on the same edge
   // that raises wr_commit / wr_rollback.
   rx_stat_counters u_stat (
      .clk          (clk),
      .rst          (rst),
      .i_ok_pulse   (w_commit),
      .i_drop_pulse (w_rollback),
      .o_ok_cnt     (frm_ok_cnt),
      .o_drop_cnt   (frm_drop_cnt)
   );

   assign wr_data     = r_wr_data;
   assign wr_en       = r_wr_en;
   assign wr_commit   = r_commit;
   assign wr_rollback = r_rollback;
   assign frm_len     = r_frm_len;

endmodule
`default_nettype wire

// File: tb/tb_rx_control.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_rx_control
// Purpose  : Self-checking bench for rx_control with a frame-level model.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module tb_rx_control;

   localparam int MIN_L = 64;
   localparam int MAX_L = 1518;

   logic        clk;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_data_valid;
   logic        rx_last_byte;
   logic        rx_error;
   logic        full_buff;
   logic [7:0]  wr_data;
   logic        wr_en;
   logic        wr_commit;
   logic        wr_rollback;
   logic [15:0] frm_len;
   logic [15:0] frm_ok_cnt;
   logic [15:0] frm_drop_cnt;

   int n_checks;
   int n_errors;

   logic [15:0] exp_len;
   logic [15:0] exp_ok;
   logic [15:0] exp_drop;

   rx_control dut (
      .clk           (clk),
      .rst           (rst),
      .rx_data       (rx_data),
      .rx_data_valid (rx_data_valid),
      .rx_last_byte  (rx_last_byte),
      .rx_error      (rx_error),
      .full_buff     (full_buff),
      .wr_data       (wr_data),
      .wr_en         (wr_en),
      .wr_commit     (wr_commit),
      .wr_rollback   (wr_rollback),
      .frm_len       (frm_len),
      .frm_ok_cnt    (frm_ok_cnt),
      .frm_drop_cnt  (frm_drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_stats(input string tag);
      check_eq({tag, "_len"},  32'(frm_len),      32'(exp_len));
      check_eq({tag, "_ok"},   32'(frm_ok_cnt),   32'(exp_ok));
      check_eq({tag, "_drop"}, 32'(frm_drop_cnt), 32'(exp_drop));
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_pulses"}, {29'd0, wr_en, wr_commit, wr_rollback}, 32'd0);
      check_eq({tag, "_data"},   32'(wr_data), 32'd0);
      check_stats(tag);
   endtask

   task automatic drive_idle(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         rx_data_valid = 1'b0;
         rx_data       = 8'($urandom);
         rx_last_byte  = 1'($urandom);
         rx_error      = 1'($urandom);
         full_buff     = 1'($urandom);
         @(posedge clk); #1;
         check_eq("idle", {29'd0, wr_en, wr_commit, wr_rollback}, 32'd0);
      end
   endtask

   // A frame is described by its length, the 1-based index of an errored byte
   // and of a byte offered while full (0 = none). The model derives the first
   // bad byte and from it which bytes land in the buffer and the verdict.
   task automatic send_frame(input string name, input int len, input int err_idx,
                             input int full_idx, input bit pattern,
                             input int gap_pct, input int rst_at);
      int          bad;
      bit          good;
      bit          wr;
      logic [7:0]  d;
      logic [31:0] exp;
      logic [31:0] obs;
      bad = 0;
      if (err_idx > 0 && err_idx <= len)
         bad = err_idx;
      if (full_idx > 0 && full_idx <= len && (bad == 0 || full_idx < bad))
         bad = full_idx;
      if (len > MAX_L && (bad == 0 || MAX_L + 1 < bad))
         bad = MAX_L + 1;
      good = (bad == 0) && (len >= MIN_L);
      for (int k = 1; k <= len; k++) begin
         while (int'($urandom_range(99)) < gap_pct)
            drive_idle(1);
         if (k == rst_at) begin
            rst = 1'b0;
            rx_data_valid = 1'b0;
            #1;
            exp_len  = '0;
            exp_ok   = '0;
            exp_drop = '0;
            check_all_zero({name, "_rst"});
            @(negedge clk);
            rst = 1'b1;
            return;
         end
         d = pattern ? 8'(k - 1) : 8'($urandom);
         rx_data_valid = 1'b1;
         rx_data       = d;
         rx_last_byte  = (k == len);
         rx_error      = (k == err_idx);
         full_buff     = (k == full_idx);
         @(posedge clk); #1;
         // The opening byte is written even when errored; never when full.
         wr  = (bad == 0 || k < bad) || (k == 1 && bad == 1 && full_idx != 1);
         exp = {21'd0, wr, (k == len) && good, (k == len) && !good, wr ? d : 8'h00};
         obs = {21'd0, wr_en, wr_commit, wr_rollback, wr_en ? wr_data : 8'h00};
         check_eq($sformatf("%s_b%0d", name, k), obs, exp);
         if (k == len) begin
            if (good) begin
               exp_len = 16'(len);
               exp_ok  = exp_ok + 16'd1;
            end else begin
               exp_drop = exp_drop + 16'd1;
            end
            check_stats(name);
         end
      end
      rx_data_valid = 1'b0;
      rx_last_byte  = 1'b0;
      rx_error      = 1'b0;
      full_buff     = 1'b0;
   endtask

   initial begin
      int len;
      int err;
      int ful;
      n_checks      = 0;
      n_errors      = 0;
      exp_len       = '0;
      exp_ok        = '0;
      exp_drop      = '0;
      rst           = 1'b0;
      rx_data       = '0;
      rx_data_valid = 1'b0;
      rx_last_byte  = 1'b0;
      rx_error      = 1'b0;
      full_buff     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst = 1'b1;
      drive_idle(2);

      send_frame("min64",   64,  0,  0, 1'b1, 0, 0);
      drive_idle(2);
      send_frame("runt63",  63,  0,  0, 1'b1, 0, 0);
      drive_idle(1);
      send_frame("err50",   100, 50, 0, 1'b1, 0, 0);
      drive_idle(1);
      send_frame("full10",  70,  0, 10, 1'b1, 0, 0);
      send_frame("b2b64",   64,  0,  0, 1'b0, 0, 0);
      send_frame("max1518", 1518, 0, 0, 1'b0, 0, 0);
      send_frame("ovr1519", 1519, 0, 0, 1'b0, 0, 0);
      send_frame("one",     1,   0,  0, 1'b0, 0, 0);
      send_frame("err1",    80,  1,  0, 1'b0, 0, 0);
      send_frame("full1",   80,  0,  1, 1'b0, 0, 0);
      send_frame("errlast", 90,  90, 0, 1'b0, 0, 0);
      send_frame("gaps65",  65,  0,  0, 1'b0, 40, 0);
      drive_idle(1);
      send_frame("rst30",   64,  0,  0, 1'b1, 0, 30);
      drive_idle(1);
      send_frame("post_rst", 64, 0,  0, 1'b1, 0, 0);

      for (int f = 0; f < 40; f++) begin
         case ($urandom_range(3))
            0:       len = int'($urandom_range(1, 63));
            1:       len = int'($urandom_range(62, 66));
            default: len = int'($urandom_range(64, 200));
         endcase
         err = ($urandom_range(3) == 0) ? int'($urandom_range(1, 200)) : 0;
         ful = ($urandom_range(3) == 0) ? int'($urandom_range(1, 200)) : 0;
         send_frame($sformatf("rnd%0d", f), len, err, ful, 1'b0,
                    int'($urandom_range(0, 30)), 0);
         drive_idle(int'($urandom_range(0, 2)));
      end
      for (int f = 0; f < 3; f++) begin
         len = int'($urandom_range(1516, 1521));
         send_frame($sformatf("long%0d", f), len, 0, 0, 1'b0, 5, 0);
      end
      drive_idle(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
